// File: rtl/alu_issue.sv
// Execute-stage issue/retire wrapper around a 32-bit ALU: S1 holds the decoded
// operands and control code, S2 holds the registered result for writeback.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rd,
  output logic [31:0] alu_da,
  output logic [31:0] alu_db,
  output logic [3:0]  alu_ctl,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic [31:0] alu_dc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_br_taken,
  output logic [31:0] out_br_target,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] CTL_ADD  = 4'b0000;
  localparam logic [3:0] CTL_SUB  = 4'b0010;
  localparam logic [3:0] CTL_AND  = 4'b0100;
  localparam logic [3:0] CTL_OR   = 4'b0101;
  localparam logic [3:0] CTL_XOR  = 4'b0110;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_SLT  = 4'b1001;
  localparam logic [3:0] CTL_SLL  = 4'b1100;
  localparam logic [3:0] CTL_SRL  = 4'b1101;
  localparam logic [3:0] CTL_SRA  = 4'b1110;

  // Overflow-trapping codes are never issued, so the flag has no consumer.
  logic unused_overflow;
  assign unused_overflow = alu_overflow;

  logic        s1_valid;
  logic        s1_branch;
  logic        s1_illegal;
  logic [1:0]  s1_br_sel;
  logic [31:0] s1_target;
  logic [4:0]  s1_rd;
  logic        s1_wen;

  logic [31:0] d_da;
  logic [31:0] d_db;
  logic [3:0]  d_ctl;
  logic        d_branch;
  logic        d_illegal;
  logic        d_wen;

  logic        s2_adv;
  logic        accept;
  logic        br_cond;
  logic        br_taken;

  always_comb begin
    d_da      = '0;
    d_db      = '0;
    d_ctl     = CTL_ADD;
    d_branch  = 1'b0;
    d_illegal = 1'b0;
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: begin
        d_da = in_rs1;
        d_db = (in_opcode == OPC_OP) ? in_rs2 : in_imm;
        case (in_funct3)
          3'b000:  d_ctl = (in_opcode == OPC_OP && in_funct7_5) ? CTL_SUB : CTL_ADD;
          3'b001:  d_ctl = CTL_SLL;
          3'b010:  d_ctl = CTL_SLT;
          3'b011:  d_ctl = CTL_SLTU;
          3'b100:  d_ctl = CTL_XOR;
          3'b101:  d_ctl = in_funct7_5 ? CTL_SRA : CTL_SRL;
          3'b110:  d_ctl = CTL_OR;
          default: d_ctl = CTL_AND;
        endcase
      end
      OPC_LUI: d_db = in_imm;
      OPC_AUIPC: begin
        d_da = in_pc;
        d_db = in_imm;
      end
      OPC_BRANCH: begin
        case (in_funct3)
          3'b000, 3'b001: d_ctl = CTL_SUB;
          3'b100, 3'b101: d_ctl = CTL_SLT;
          3'b110, 3'b111: d_ctl = CTL_SLTU;
          default:        d_illegal = 1'b1;
        endcase
        if (!d_illegal) begin
          d_da     = in_rs1;
          d_db     = in_rs2;
          d_branch = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase
    d_wen = ~d_illegal & ~d_branch & (in_rd != 5'd0);
  end

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~flush & (~s1_valid | s2_adv);
  assign accept   = in_valid & in_ready;

  // funct3[2] picks the flag (zero vs. set-less-than bit), funct3[0] inverts it.
  assign br_cond  = s1_br_sel[1] ? alu_dc[0] : alu_zero;
  assign br_taken = s1_branch & (br_cond ^ s1_br_sel[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      alu_da     <= '0;
      alu_db     <= '0;
      alu_ctl    <= '0;
      s1_branch  <= 1'b0;
      s1_illegal <= 1'b0;
      s1_br_sel  <= '0;
      s1_target  <= '0;
      s1_rd      <= '0;
      s1_wen     <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      alu_da     <= d_da;
      alu_db     <= d_db;
      alu_ctl    <= d_ctl;
      s1_branch  <= d_branch;
      s1_illegal <= d_illegal;
      s1_br_sel  <= {in_funct3[2], in_funct3[0]};
      s1_target  <= in_pc + in_imm;
      s1_rd      <= in_rd;
      s1_wen     <= d_wen;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_wen       <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid     <= 1'b1;
      out_result    <= (s1_branch | s1_illegal) ? 32'd0 : alu_dc;
      out_rd        <= s1_rd;
      out_wen       <= s1_wen;
      out_br_taken  <= br_taken;
      out_br_target <= s1_target;
      out_illegal   <= s1_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU closing the loop on
// alu_da/alu_db/alu_ctl.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic [31:0] alu_da;
  logic [31:0] alu_db;
  logic [3:0]  alu_ctl;
  logic        alu_zero;
  logic        alu_overflow;
  logic [31:0] alu_dc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_br_taken;
  logic [31:0] out_br_target;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] BR  = 7'b1100011;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .alu_da(alu_da), .alu_db(alu_db), .alu_ctl(alu_ctl),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_dc(alu_dc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctl)
      4'b0000: alu_dc = alu_da + alu_db;
      4'b0010: alu_dc = alu_da - alu_db;
      4'b0100: alu_dc = alu_da & alu_db;
      4'b0101: alu_dc = alu_da | alu_db;
      4'b0110: alu_dc = alu_da ^ alu_db;
      4'b1000: alu_dc = {31'd0, alu_da < alu_db};
      4'b1001: alu_dc = {31'd0, $signed(alu_da) < $signed(alu_db)};
      4'b1100: alu_dc = alu_da << alu_db[4:0];
      4'b1101: alu_dc = alu_da >> alu_db[4:0];
      4'b1110: alu_dc = $unsigned($signed(alu_da) >>> alu_db[4:0]);
      default: alu_dc = 32'd0;
    endcase
  end
  assign alu_zero     = (alu_dc == 32'd0);
  assign alu_overflow = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_funct3   = f3;
    in_funct7_5 = f75;
    in_pc       = pc;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_rd       = rd;
  endtask

  // Entered at a negedge with S1 free; checks S1 one edge later and S2 two edges later.
  task automatic run_one(input string tag,
                         input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic [3:0] e_ctl, input logic [31:0] e_da, input logic [31:0] e_db,
                         input logic [31:0] e_res, input logic e_wen, input logic e_taken,
                         input logic [31:0] e_target, input logic e_ill);
    drive(op, f3, f75, pc, rs1, rs2, imm, rd);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_ctl"}, {28'd0, alu_ctl}, {28'd0, e_ctl});
    chk({tag, "_da"}, alu_da, e_da);
    chk({tag, "_db"}, alu_db, e_db);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, out_result, e_res);
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, "_wen"}, {31'd0, out_wen}, {31'd0, e_wen});
    chk({tag, "_taken"}, {31'd0, out_br_taken}, {31'd0, e_taken});
    chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
    if (op == BR && !e_ill) chk({tag, "_target"}, out_br_target, e_target);
  endtask

  logic [6:0]  v_op  [4] = '{OP, OP, OP, OPI};
  logic [2:0]  v_f3  [4] = '{3'b000, 3'b000, 3'b100, 3'b110};
  logic        v_f75 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] v_rs1 [4] = '{32'd1, 32'd10, 32'h0F0, 32'h100};
  logic [31:0] v_rs2 [4] = '{32'd2, 32'd3, 32'h0FF, 32'd0};
  logic [31:0] v_imm [4] = '{32'd0, 32'd0, 32'd0, 32'd1};
  logic [31:0] v_res [4] = '{32'd3, 32'd7, 32'h00F, 32'h101};

  initial begin
    int acc;
    int ret;
    logic [31:0] held;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_opcode = '0;
    in_funct3 = '0;
    in_funct7_5 = 1'b0;
    in_pc = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_imm = '0;
    in_rd = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("rst_alu_da", alu_da, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_one("add", OP, 3'b000, 1'b0, 32'd0, 32'd5, 32'd7, 32'd0, 5'd3,
            4'b0000, 32'd5, 32'd7, 32'd12, 1'b1, 1'b0, 32'd0, 1'b0);
    run_one("sra", OP, 3'b101, 1'b1, 32'd0, 32'h80000000, 32'd4, 32'd0, 5'd5,
            4'b1110, 32'h80000000, 32'd4, 32'hF8000000, 1'b1, 1'b0, 32'd0, 1'b0);
    run_one("sltiu", OPI, 3'b011, 1'b0, 32'd0, 32'd1, 32'h55, 32'hFFFFFFFF, 5'd6,
            4'b1000, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 32'd0, 1'b0);
    run_one("blt", BR, 3'b100, 1'b0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd7,
            4'b1001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 32'h120, 1'b0);
    run_one("bgeu", BR, 3'b111, 1'b0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd7,
            4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1, 32'h120, 1'b0);
    run_one("bne_eq", BR, 3'b001, 1'b0, 32'h200, 32'd5, 32'd5, 32'hFFFFFFF0, 5'd8,
            4'b0010, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 32'h1F0, 1'b0);
    run_one("load_ill", 7'b0000011, 3'b010, 1'b0, 32'h40, 32'd9, 32'd9, 32'd4, 5'd9,
            4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    run_one("br_ill", BR, 3'b010, 1'b0, 32'h40, 32'd9, 32'd8, 32'd4, 5'd10,
            4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    run_one("add_rd0", OP, 3'b000, 1'b0, 32'd0, 32'd3, 32'd4, 32'd0, 5'd0,
            4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    run_one("auipc", AUI, 3'b000, 1'b0, 32'h1000, 32'd77, 32'd88, 32'h2000, 5'd11,
            4'b0000, 32'h1000, 32'h2000, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back issue with retire stalled for the first five cycles.
    acc = 0;
    ret = 0;
    held = '0;
    for (int c = 0; c < 40 && ret < 4; c++) begin
      out_ready = (c >= 5);
      if (acc < 4) drive(v_op[acc], v_f3[acc], v_f75[acc], 32'd0, v_rs1[acc], v_rs2[acc], v_imm[acc], 5'(acc + 1));
      else in_valid = 1'b0;
      #1;
      if (c == 2) begin
        chk("stall_accepted", acc, 2);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_first", out_result, v_res[0]);
        held = out_result;
      end
      if (c == 3 || c == 4) begin
        chk("stall_hold_result", out_result, held);
        chk("stall_hold_rd", {27'd0, out_rd}, 32'd1);
        chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        chk("retire_result", out_result, v_res[ret]);
        chk("retire_rd", {27'd0, out_rd}, ret + 1);
        ret++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("retired_count", ret, 4);
    chk("after_stream_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both stages full; the same-cycle issue must be dropped.
    out_ready = 1'b0;
    drive(OP, 3'b000, 1'b0, 32'd0, 32'd1, 32'd1, 32'd0, 5'd1);
    @(posedge clk);
    @(negedge clk);
    drive(OP, 3'b000, 1'b0, 32'd0, 32'd2, 32'd2, 32'd0, 5'd2);
    @(posedge clk);
    @(negedge clk);
    drive(OP, 3'b000, 1'b0, 32'd0, 32'd3, 32'd3, 32'd0, 5'd3);
    flush = 1'b1;
    #1;
    chk("flush_full_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_s1_empty", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between clock edges with the pipeline full.
    out_ready = 1'b0;
    drive(OP, 3'b110, 1'b0, 32'd0, 32'h50, 32'h0A, 32'd0, 5'd4);
    @(posedge clk);
    @(negedge clk);
    drive(OP, 3'b000, 1'b0, 32'd0, 32'h60, 32'h01, 32'd0, 5'd5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_result", out_result, 32'h5A);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", out_result, 32'd0);
    chk("async_rst_rd", {27'd0, out_rd}, 32'd0);
    chk("async_rst_da", alu_da, 32'd0);
    chk("async_rst_db", alu_db, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
